// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: sweeps all 8 minterms of a 3-input function, captures Y into a truth table and compares it to a golden mask
module func_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       y_in,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic [7:0] mask,
    output logic       match,
    output logic [2:0] fail_idx
);
    typedef enum logic [1:0] {IDLE, APPLY, FINISH} state_t;
    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [7:0] next_mask;
    logic [7:0] diff;
    logic [2:0] first_diff;
    // Compare against the mask including the bit captured on this edge
    always_comb begin
        next_mask = mask;
        next_mask[idx] = y_in;
        diff = next_mask ^ expected;
        first_diff = 3'd0;
        for (int i = 7; i >= 0; i--)
            first_diff = diff[i] ? 3'(i) : first_diff;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 4'd0;
            mask      <= 8'd0;
            {A, B, C} <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            fail_idx  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mask      <= 8'd0;
                        match     <= 1'b0;
                        fail_idx  <= 3'd0;
                        idx       <= 3'd0;
                        cnt       <= 4'd0;
                        busy      <= 1'b1;
                        {A, B, C} <= 3'd0;
                        state     <= APPLY;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        {A, B, C} <= 3'd0;
                        match     <= 1'b0;
                    end else if (cnt != 4'(SETTLE)) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        mask <= next_mask;
                        cnt  <= 4'd0;
                        if (idx == 3'd7) begin
                            state     <= FINISH;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            {A, B, C} <= 3'd0;
                            match     <= (diff == 8'd0);
                            fail_idx  <= first_diff;
                        end else begin
                            idx       <= idx + 3'd1;
                            {A, B, C} <= idx + 3'd1;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_func_sweep_ctrl.sv
// tb_func_sweep_ctrl: scoreboard bench driving two sweepers (SETTLE=1 and SETTLE=0) against a truth-table model
module tb_func_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [1:0] start_v = 2'b00, abort_v = 2'b00;
    logic [1:0] a_v, b_v, c_v, busy_v, done_v, match_v, y_v;
    logic [7:0] expected = 8'd0, fmask = 8'hAB;
    logic [7:0] mask0, mask1;
    logic [2:0] fi0, fi1;
    assign y_v[0] = fmask[{a_v[0], b_v[0], c_v[0]}];
    assign y_v[1] = fmask[{a_v[1], b_v[1], c_v[1]}];
    func_sweep_ctrl #(.SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .expected(expected),
        .y_in(y_v[0]), .A(a_v[0]), .B(b_v[0]), .C(c_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .mask(mask0), .match(match_v[0]), .fail_idx(fi0));
    func_sweep_ctrl #(.SETTLE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .expected(expected),
        .y_in(y_v[1]), .A(a_v[1]), .B(b_v[1]), .C(c_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .mask(mask1), .match(match_v[1]), .fail_idx(fi1));
    typedef struct {
        int         dcyc;
        logic [7:0] m;
        logic       mt;
        logic [2:0] fi;
    } exp_t;
    exp_t q0[$], q1[$];
    int st[2] = '{-1, -1};
    int cyc = 0;
    int checks = 0, failures = 0;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic int per(input int d);
        return d == 0 ? 2 : 1;
    endfunction
    function automatic int ref_fidx(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 8; i++)
            if (a[i] != b[i]) return i;
        return 0;
    endfunction
    function automatic int qsize(input int d);
        return d == 0 ? q0.size() : q1.size();
    endfunction
    function automatic exp_t qpop(input int d);
        return d == 0 ? q0.pop_front() : q1.pop_front();
    endfunction
    function automatic exp_t qfront(input int d);
        return d == 0 ? q0[0] : q1[0];
    endfunction
    task automatic chk(input string n, input int d, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s dut%0d at cycle %0d: got=%0d want=%0d", n, d, cyc, act, want);
        end
    endtask
    function automatic int abc(input int d);
        return int'({a_v[d], b_v[d], c_v[d]});
    endfunction
    task automatic mon(input int d);
        int p, k;
        exp_t e;
        p = per(d);
        if (st[d] >= 0) begin
            k = cyc - st[d];
            if (k >= 0 && k < 8 * p) begin
                chk("busy", d, int'(busy_v[d]), 1);
                chk("abc", d, abc(d), k / p);
                chk("no_done", d, int'(done_v[d]), 0);
            end else if (k >= 8 * p) st[d] = -1;
        end
        if (done_v[d]) begin
            if (qsize(d) == 0) chk("spurious_done", d, 1, 0);
            else begin
                e = qpop(d);
                chk("done_cyc", d, cyc, e.dcyc);
                chk("mask", d, int'(d ? mask1 : mask0), int'(e.m));
                chk("match", d, int'(match_v[d]), int'(e.mt));
                chk("fail_idx", d, int'(d ? fi1 : fi0), int'(e.fi));
                chk("busy_fin", d, int'(busy_v[d]), 0);
                chk("abc_fin", d, abc(d), 0);
            end
        end else if (qsize(d) > 0 && cyc > qfront(d).dcyc) begin
            e = qpop(d);
            chk("done_timeout", d, cyc, e.dcyc);
        end
    endtask
    always @(negedge clk) if (rst_n) begin
        mon(0);
        mon(1);
    end
    task automatic push_exp(input int d, input logic [7:0] ev);
        exp_t e;
        e.dcyc = cyc + 1 + 8 * per(d);
        e.m = fmask;
        e.mt = (fmask == ev);
        e.fi = 3'(ref_fidx(fmask, ev));
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        st[d] = cyc + 1;
    endtask
    task automatic do_start(input int d, input logic [7:0] ev, input logic ab);
        @(negedge clk);
        expected = ev;
        start_v[d] = 1'b1;
        abort_v[d] = ab;
        push_exp(d, ev);
        @(negedge clk);
        start_v[d] = 1'b0;
        abort_v[d] = 1'b0;
    endtask
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask
    task automatic wait_done(input int d);
        repeat (8 * per(d) + 3) @(negedge clk);
    endtask
    task automatic chk_zero(input string n, input int d);
        chk({n, "_abc"}, d, abc(d), 0);
        chk({n, "_busy"}, d, int'(busy_v[d]), 0);
        chk({n, "_done"}, d, int'(done_v[d]), 0);
        chk({n, "_mask"}, d, int'(d ? mask1 : mask0), 0);
        chk({n, "_match"}, d, int'(match_v[d]), 0);
        chk({n, "_fidx"}, d, int'(d ? fi1 : fi0), 0);
    endtask
    initial begin
        int s, d;
        logic [7:0] ev;
        #12;
        chk_zero("reset", 0);
        chk_zero("reset", 1);
        @(negedge clk);
        rst_n = 1'b1;
        fmask = 8'hAB;
        do_start(0, 8'hAB, 1'b0);
        wait_done(0);
        do_start(0, 8'hCC, 1'b0);
        wait_done(0);
        do_start(1, 8'hAB, 1'b0);
        wait_done(1);
        // abort on the edge that would capture minterm 4
        do_start(0, 8'hAB, 1'b0);
        s = st[0];
        wait_until(s + 4 * 2 + 1);
        abort_v[0] = 1'b1;
        void'(q0.pop_back());
        st[0] = -1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("abort_busy", 0, int'(busy_v[0]), 0);
        chk("abort_mask", 0, int'(mask0), int'(fmask & 8'h0F));
        chk("abort_match", 0, int'(match_v[0]), 0);
        chk("abort_abc", 0, abc(0), 0);
        wait_done(0);
        // asynchronous reset mid-sweep, then start right after release
        do_start(0, 8'hAB, 1'b0);
        s = st[0];
        wait_until(s + 5 * 2);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        st[0] = -1;
        st[1] = -1;
        #1;
        chk_zero("async_rst", 0);
        #1;
        rst_n = 1'b1;
        start_v[0] = 1'b1;
        push_exp(0, 8'hAB);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0);
        // start re-pulsed mid-sweep must be ignored
        fmask = 8'h5E;
        do_start(0, 8'h5E, 1'b0);
        s = st[0];
        wait_until(s + 3 * 2);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0);
        for (int it = 0; it < 16; it++) begin
            d = int'($urandom_range(1, 0));
            fmask = 8'($urandom);
            case ($urandom_range(2, 0))
                0: ev = fmask;
                1: ev = fmask ^ (8'd1 << $urandom_range(7, 0));
                default: ev = 8'($urandom);
            endcase
            do_start(d, ev, 1'($urandom_range(1, 0)));
            s = st[d];
            @(negedge clk);
            expected = 8'($urandom);
            wait_until(s + 8 * per(d) - 1);
            expected = ev;
            repeat (4) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("queue_drained", 0, q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/func_sweep_ctrl.md
FUNC_SWEEP_CTRL -- requirements
Module: func_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning the number of wait cycles between driving a minterm and sampling Y; legal range 0..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to begin a sweep; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, which cancels a sweep in progress.
REQ-006 SHALL have port expected, input, 8, the golden minterm mask, where bit i = F(i).
REQ-007 SHALL have port y_in, input, 1, the output Y of the 3-input function under test.
REQ-008 SHALL have ports A, B and C, each output, 1, the function inputs, with minterm index = {A,B,C} and A as MSB.
REQ-009 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port mask, output, 8, the captured truth table, where bit i = sampled Y for minterm i.
REQ-012 SHALL have port match, output, 1, equal to (mask == expected), valid from done until the next start.
REQ-013 SHALL have port fail_idx, output, 3, the lowest minterm index where mask and expected differ; 0 when match=1.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, FINISH, all registered.
REQ-015 IDLE: SHALL drive {A,B,C}=3'b000 and busy=0; on start=1, SHALL clear mask, match and fail_idx, set idx=0 and cnt=0, and go to APPLY.
REQ-016 APPLY: SHALL drive {A,B,C}=idx and busy=1.
REQ-017 APPLY with cnt<SETTLE: SHALL increment cnt.
REQ-018 APPLY with cnt==SETTLE: SHALL capture mask[idx]<=y_in, set cnt=0, and either increment idx or, if idx==7, go to FINISH.
REQ-019 Each minterm SHALL occupy exactly SETTLE+1 cycles.
REQ-020 The last capture SHALL occur on edge 8*(SETTLE+1) counted from the start-sampling edge.
REQ-021 FINISH: SHALL assert done=1 for exactly one cycle, update match and fail_idx from the completed mask, set busy=0, drive {A,B,C}=0, and return to IDLE on the next edge.
REQ-022 match and fail_idx SHALL be computed combinationally from the final mask and registered at the transition into FINISH, so both are valid in the same cycle done=1.
REQ-023 match and fail_idx SHALL hold until the next accepted start.
REQ-024 start while busy=1 or in FINISH SHALL be ignored, with no restart and no queuing.
REQ-025 abort=1 in APPLY SHALL go to IDLE on the next edge: no done pulse, mask keeps only the bits captured so far, and match=0.
REQ-026 abort SHALL take priority over a capture on the same edge.
REQ-027 abort in IDLE or FINISH SHALL have no effect.
REQ-028 start and abort both high in IDLE SHALL start the sweep, since abort is ignored there.
REQ-029 idx SHALL be 3 bits wide and SHALL never wrap from 7 to 0 within a sweep; reaching index 7 ends the sweep.
REQ-030 expected SHALL be sampled only at the transition into FINISH; changes mid-sweep SHALL have no effect before that point.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=IDLE, idx=0, cnt=0, mask=0, {A,B,C}=0, busy=0, done=0, match=0, fail_idx=0.
REQ-032 Reset asserted mid-sweep SHALL discard all progress; no done pulse SHALL follow.
REQ-033 On rst_n release, the first start SHALL be accepted on the first rising edge after deassertion.

Verification
REQ-034 Bench SHALL cover: SETTLE=1, DUT F=m(0,1,3,5,7), expected=8'hAB, pulse start -> minterms 0..7 each held 2 cycles, done at edge 16, mask=8'hAB, match=1, fail_idx=0.
REQ-035 Bench SHALL cover: same DUT, expected=8'hCC (m(2,3,6,7)) -> mask=8'hAB, match=0, fail_idx=0.
REQ-036 Bench SHALL cover: SETTLE=0, expected=8'hAB -> {A,B,C} steps 0..7 one per cycle, done at edge 8, match=1.
REQ-037 Bench SHALL cover: abort asserted while idx=4 -> busy falls next edge, no done pulse, mask[7:4]=0, match=0.
REQ-038 Bench SHALL cover: rst_n pulsed low while idx=5 -> all outputs 0 immediately without a clock edge; a new start then gives a full sweep with correct mask.
REQ-039 Bench SHALL cover: start re-pulsed at idx=3 -> ignored, done still at edge 8*(SETTLE+1), mask unchanged from a clean sweep.
